// File: rtl/fpu_int_to_extended.sv
// Normalizes an unsigned 64-bit integer (with sign and error flag) into an 80-bit extended real.
// Optional macro FPU_INT_NORM_FAST_SHIFT_EN enables 8-bit skip shifts in the normalizer.
module fpu_int_to_extended #(
    parameter int unsigned EXP_BIAS = 16383
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] binary_in,
    input  logic        sign_in,
    input  logic        error_in,
    output logic [79:0] extended_out,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {StIdle, StNormalize, StDone} state_e;

    localparam logic [14:0] ExpTop = 15'(EXP_BIAS + 63);
    localparam logic [79:0] RealIndefinite = 80'hFFFF_C000_0000_0000_0000;

    state_e      state_q, state_d;
    logic [63:0] mant_q, mant_d;
    logic [5:0]  count_q, count_d;
    logic        sign_q, sign_d;
    logic [79:0] ext_q, ext_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [14:0] exponent;

    assign exponent     = ExpTop - {9'd0, count_q};
    assign extended_out = ext_q;
    assign done         = done_q;
    assign error        = error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            mant_q  <= '0;
            count_q <= '0;
            sign_q  <= 1'b0;
            ext_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            count_q <= count_d;
            sign_q  <= sign_d;
            ext_q   <= ext_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        count_d = count_q;
        sign_d  = sign_q;
        ext_d   = ext_q;
        done_d  = done_q;
        error_d = error_q;
        unique case (state_q)
            StIdle: begin
                done_d  = 1'b0;
                error_d = 1'b0;
                if (enable) begin
                    sign_d = sign_in;
                    if (error_in) begin
                        ext_d   = RealIndefinite;
                        error_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (binary_in == 64'd0) begin
                        ext_d   = {sign_in, 79'd0};
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        mant_d  = binary_in;
                        count_d = 6'd0;
                        state_d = StNormalize;
                    end
                end
            end
            StNormalize: begin
                if (mant_q[63]) begin
                    ext_d   = {sign_q, exponent, mant_q};
                    done_d  = 1'b1;
                    state_d = StDone;
`ifdef FPU_INT_NORM_FAST_SHIFT_EN
                end else if (mant_q[63:56] == 8'd0) begin
                    mant_d  = mant_q << 8;
                    count_d = count_q + 6'd8;
`endif
                end else begin
                    mant_d  = mant_q << 1;
                    count_d = count_q + 6'd1;
                end
            end
            StDone: begin
                // done is registered, so clearing here keeps a dropped-enable pulse to one cycle
                if (!enable) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: doc/fpu_int_to_extended.md
Name: fpu_int_to_extended

Overview:
- Downstream stage of the packed-BCD load path (FBLD).
- Consumes the 64-bit unsigned magnitude, sign and error flag produced by the BCD-to-binary converter.
- Normalizes the magnitude into an 80-bit 8087 extended-precision real: sign, 15-bit biased exponent, 64-bit mantissa with explicit integer bit.
- Multi-cycle iterative left-shift normalizer using the same level enable/done handshake as the converter.

Parameters:
- EXP_BIAS, 16383, extended-precision exponent bias.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  level request; sampled in IDLE; must stay high until done seen
- binary_in  input  64  unsigned integer magnitude
- sign_in  input  1  sign of integer (1 = negative)
- error_in  input  1  upstream invalid-BCD flag
- extended_out  output  80  [79] sign, [78:64] biased exponent, [63:0] mantissa
- done  output  1  result valid; held until enable deasserts
- error  output  1  result is an invalid-operand result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- Reset values: extended_out = 0, done = 0, error = 0, state = IDLE, internal mantissa and shift count = 0.
- Reset in any state, including mid-normalization, aborts the operation; module is in IDLE on the next cycle.
- States: IDLE, NORMALIZE, DONE.
- IDLE:
  - done <= 0 and error <= 0 every cycle; extended_out holds its last value.
  - On enable = 1, capture inputs, then take exactly one of these branches:
  - error_in = 1: extended_out <= 0xFFFF_C000_0000_0000_0000 (real indefinite); error <= 1; done <= 1; go to DONE.
  - Else binary_in == 0: extended_out <= {sign_in, 79'b0} (signed zero); done <= 1; go to DONE.
  - Else: mantissa <= binary_in; shift count <= 0; sign latched; go to NORMALIZE.
- NORMALIZE, one action per cycle:
  - mantissa[63] = 1: extended_out <= {sign, EXP_BIAS + 63 - count (15 bits), mantissa}; done <= 1; go to DONE.
  - Otherwise: mantissa <= mantissa << 1; count <= count + 1.
- Arithmetic:
  - Count is 6 bits, range 0..63.
  - Exponent = EXP_BIAS + 63 - count; range 0x3FFF..0x403E. No overflow or denormal is possible.
- Latency (nonzero, no error):
  - lz = leading-zero count of binary_in.
  - done rises lz+1 cycles after the capture edge.
  - Zero and error inputs complete on the capture edge itself.
- DONE:
  - done = 1 held, outputs stable.
  - When enable = 0, go to IDLE; done clears on the following cycle.
- enable dropped during NORMALIZE: conversion still completes. DONE is entered with enable low, so done is high for exactly one cycle.
- Inputs are ignored outside IDLE; changing binary_in mid-operation has no effect.

Optional Feature:
- Macro: FPU_INT_NORM_FAST_SHIFT_EN.
- Defined: in NORMALIZE, if mantissa[63:56] == 0, shift by 8 and count += 8; else use the 1-bit rule above.
  - Latency becomes floor(lz/8) + (lz mod 8) + 1 cycles.
  - Results are bit-identical to the baseline.
- Undefined: 1-bit-per-cycle shifting only.

Test Plan:
- binary_in = 1, sign_in = 0, enable held → after 64 cycles (fast: 15): extended_out = 0x3FFF_8000_0000_0000_0000, done = 1, error = 0.
- binary_in = 0x0DE0_B6B3_A763_FFFF, sign_in = 1 → after 5 cycles: extended_out = 0xC03A_DE0B_6B3A_763F_FFF0.
- binary_in = 0x8000_0000_0000_0000 → 1 cycle, exponent 0x403E, mantissa unchanged. binary_in = 0 with sign_in = 1 → capture edge, extended_out = 0x8000_0000_0000_0000_0000.
- error_in = 1, any binary_in → capture edge: extended_out = 0xFFFF_C000_0000_0000_0000, error = 1, done = 1; both clear one cycle after enable drops.
- Reset asserted 3 cycles into normalizing binary_in = 1 → next cycle: state IDLE, done = 0, extended_out = 0. A fresh enable with binary_in = 2 yields 0x4000_8000_0000_0000_0000.
- enable pulsed for 1 cycle with binary_in = 0xFF → done high for exactly one cycle after 57 cycles (fast: 8), extended_out = 0x4006_FF00_0000_0000_0000.
